param_stream_fifo: RTL and testbench
====================================

Name: param_stream_fifo

Overview:
Parametrised valid/ready stream buffer for the datapath. It extends the WIDTH/DEPTH/INIT_VAL/MODE parameter set with real storage, flow control, occupancy reporting and two output modes. The block sits between a producer driving data_in and a consumer of data_out. It absorbs backpressure and rate mismatch.

Parameters:
WIDTH, 8, data word width in bits (>=1).
DEPTH, 16, RAM entries; power of two, >=2.
INIT_VAL, 0, value driven on data_out after reset, after flush, and whenever out_valid=0.
MODE, 1, 0 = registered-output mode (extra output register stage); 1 = first-word-fall-through.
AFULL_LVL, DEPTH-2, almost_full threshold on count; 1..DEPTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all contents.
data_in  input  WIDTH  write data.
in_valid  input  1  producer has a word on data_in.
in_ready  output  1  FIFO can accept a word this cycle.
data_out  output  WIDTH  head word, registered.
out_valid  output  1  data_out holds a valid word.
out_ready  input  1  consumer accepts data_out this cycle.
count  output  $clog2(DEPTH)+2  words held; includes the output register in MODE 0.
almost_full  output  1  count >= AFULL_LVL.
overflow  output  1  sticky flag: in_valid=1 while in_ready=0.

Behaviour:
- Reset (async assert, sync release): pointers=0; count=0; out_valid=0; data_out=INIT_VAL; in_ready=1; almost_full=0; overflow=0.
- Pointer width is AW=$clog2(DEPTH), plus one wrap bit. Pointers wrap DEPTH-1 -> 0.
  - empty: pointers are fully equal.
  - full: address bits equal, wrap bits differ.
- in_ready = !full. The RAM is not considered full if the only slot freeing this cycle is being read: no pass-through when full.
- A write occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- Blocked writes:
  - in_valid && !in_ready sets overflow.
  - The word is not stored.
  - overflow clears only on reset or flush.
- MODE 1 (FWFT):
  - out_valid = RAM not empty.
  - data_out = RAM[rd_ptr] when out_valid, else INIT_VAL.
  - A write into an empty FIFO gives out_valid=1 one cycle after the write edge.
  - A pop advances rd_ptr; the next word appears the following cycle.
  - count = RAM occupancy, max DEPTH.
- MODE 0 (registered output):
  - Output register loads from the RAM when it is empty, or when it is popped, and the RAM is non-empty.
  - A write into an empty FIFO gives out_valid=1 two cycles after the write edge.
  - A simultaneous pop and RAM non-empty gives back-to-back output with no bubble.
  - count = RAM occupancy + out_valid, max DEPTH+1.
  - data_out = INIT_VAL when out_valid=0.
- Simultaneous write and pop: count is unchanged. Allowed at any occupancy where in_ready=1.
- Write into an empty FIFO with out_ready=1: no bypass. The word follows the mode latency above.
- flush:
  - Highest priority over write and pop in the same cycle.
  - Next cycle: count=0, out_valid=0, data_out=INIT_VAL, overflow=0, pointers=0.
  - The write on the flush cycle is discarded.
- count, almost_full and in_ready are registered-state derived. They update the cycle after the causing edge, with no combinational path from in_valid or out_ready.
- Reset asserted mid-transfer: immediate return to reset values; contents are lost.
- Word order is strict FIFO in both modes. Data is never duplicated or dropped except by flush, reset, or blocked writes.

Test Plan:
1. MODE 1, DEPTH=4: write 0x11 at cycle 0, out_ready=0 -> cycle 1 out_valid=1, data_out=0x11, count=1; assert out_ready -> cycle 2 out_valid=0, data_out=INIT_VAL, count=0.
2. MODE 1, DEPTH=4, AFULL_LVL=3: write 0x01..0x04 back-to-back -> almost_full after 3rd write, in_ready=0 after 4th; drive 0x05 -> overflow=1, 0x05 never appears; drain reads 0x01..0x04 in order.
3. MODE 0, DEPTH=4: fill 5 words 0xA0..0xA4 with out_ready=0 -> count=5, in_ready=0; out_ready=1 continuous -> data_out A0,A1,A2,A3,A4 on consecutive cycles, no bubbles.
4. Either mode at half occupancy (count=2): simultaneous write and pop every cycle for 20 cycles across pointer wrap -> count stays 2; output sequence equals input sequence delayed.
5. count=3 with overflow=1: assert flush together with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, overflow=0, data_out=INIT_VAL; the flush-cycle write is absent.
6. Assert rst_n=0 asynchronously between edges with count=2 -> outputs reach reset values before the next clock edge; after release, the first write behaves as scenario 1.

Source files
------------

// File: rtl/param_stream_fifo.sv
// Valid/ready stream FIFO with occupancy, almost-full and sticky overflow reporting.
// MODE 1 presents the RAM head directly (FWFT); MODE 0 adds a registered output stage.
module param_stream_fifo #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 16,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0,
  parameter int unsigned      MODE      = 1,
  parameter int unsigned      AFULL_LVL = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH)+1:0]  count,
  output logic                      almost_full,
  output logic                      overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 2;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             ram_empty, ram_full;
  logic             wr_en, rd_en;
  logic             out_stage_bit;
  logic [AW:0]      ram_occ;
  logic [WIDTH-1:0] ram_head;

  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign ram_occ   = wr_ptr_q - rd_ptr_q;
  assign ram_head  = mem_q[rd_ptr_q[AW-1:0]];

  // Full is judged on registered state only, so a same-cycle read never frees a slot.
  assign in_ready = !ram_full;
  assign wr_en    = in_valid && !ram_full && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (in_valid && ram_full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  if (MODE == 0) begin : g_reg_out
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pop, load;

    assign pop   = out_valid_q && out_ready;
    assign load  = !ram_empty && (!out_valid_q || out_ready);
    assign rd_en = load && !flush;

    always_comb begin
      out_valid_d = out_valid_q;
      data_out_d  = data_out_q;
      if (flush) begin
        out_valid_d = 1'b0;
        data_out_d  = INIT_VAL;
      end else if (load) begin
        out_valid_d = 1'b1;
        data_out_d  = ram_head;
      end else if (pop) begin
        out_valid_d = 1'b0;
        data_out_d  = INIT_VAL;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        data_out_q  <= INIT_VAL;
      end else begin
        out_valid_q <= out_valid_d;
        data_out_q  <= data_out_d;
      end
    end

    assign out_valid     = out_valid_q;
    assign data_out      = data_out_q;
    assign out_stage_bit = out_valid_q;
  end else begin : g_fwft
    assign out_valid     = !ram_empty;
    assign data_out      = ram_empty ? INIT_VAL : ram_head;
    assign rd_en         = !ram_empty && out_ready && !flush;
    assign out_stage_bit = 1'b0;
  end

  // The output register counts as one held word in MODE 0.
  assign count       = {1'b0, ram_occ} + {{(CW-1){1'b0}}, out_stage_bit};
  assign almost_full = (count >= CW'(AFULL_LVL));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_param_stream_fifo.sv
// Directed bench: one FWFT instance and one registered-output instance, both DEPTH=4.
module tb_param_stream_fifo;

  logic       clk;
  logic       rst_n;

  logic       f_flush, f_iv, f_ir, f_ov, f_or, f_af, f_ovf;
  logic [7:0] f_din, f_dout;
  logic [3:0] f_cnt;

  logic       r_flush, r_iv, r_ir, r_ov, r_or, r_af, r_ovf;
  logic [7:0] r_din, r_dout;
  logic [3:0] r_cnt;

  int n_pass;
  int n_total;

  param_stream_fifo #(
    .WIDTH(8), .DEPTH(4), .INIT_VAL(8'hEE), .MODE(1), .AFULL_LVL(3)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .data_in(f_din), .in_valid(f_iv),
    .in_ready(f_ir), .data_out(f_dout), .out_valid(f_ov), .out_ready(f_or),
    .count(f_cnt), .almost_full(f_af), .overflow(f_ovf)
  );

  param_stream_fifo #(
    .WIDTH(8), .DEPTH(4), .INIT_VAL(8'h5A), .MODE(0)
  ) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(r_flush), .data_in(r_din), .in_valid(r_iv),
    .in_ready(r_ir), .data_out(r_dout), .out_valid(r_ov), .out_ready(r_or),
    .count(r_cnt), .almost_full(r_af), .overflow(r_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    {f_flush, f_iv, f_or} = '0;
    {r_flush, r_iv, r_or} = '0;
    f_din = '0;
    r_din = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    check("rst_f_ov",   f_ov,   0);
    check("rst_f_dout", f_dout, 8'hEE);
    check("rst_f_cnt",  f_cnt,  0);
    check("rst_f_ir",   f_ir,   1);
    check("rst_f_af",   f_af,   0);
    check("rst_f_ovf",  f_ovf,  0);
    check("rst_r_ov",   r_ov,   0);
    check("rst_r_dout", r_dout, 8'h5A);
    check("rst_r_cnt",  r_cnt,  0);
    check("rst_r_ir",   r_ir,   1);

    // FWFT single word: visible the cycle after the write, gone the cycle after the pop.
    f_din = 8'h11; f_iv = 1'b1;
    step();
    f_iv = 1'b0;
    check("s1_ov",   f_ov,   1);
    check("s1_dout", f_dout, 8'h11);
    check("s1_cnt",  f_cnt,  1);
    f_or = 1'b1;
    step();
    f_or = 1'b0;
    check("s1_pop_ov",   f_ov,   0);
    check("s1_pop_dout", f_dout, 8'hEE);
    check("s1_pop_cnt",  f_cnt,  0);

    // Fill to full, then a blocked write.
    f_iv = 1'b1;
    f_din = 8'h01; step();
    check("s2_cnt1", f_cnt, 1);
    check("s2_af1",  f_af,  0);
    f_din = 8'h02; step();
    check("s2_af2",  f_af,  0);
    f_din = 8'h03; step();
    check("s2_cnt3", f_cnt, 3);
    check("s2_af3",  f_af,  1);
    check("s2_ir3",  f_ir,  1);
    f_din = 8'h04; step();
    check("s2_cnt4", f_cnt, 4);
    check("s2_ir4",  f_ir,  0);
    check("s2_ovf0", f_ovf, 0);
    f_din = 8'h05; step();
    f_iv = 1'b0;
    check("s2_ovf1",  f_ovf, 1);
    check("s2_cntb",  f_cnt, 4);
    f_or = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("s2_drain_ov",   f_ov,   1);
      check("s2_drain_dout", f_dout, i);
      step();
    end
    f_or = 1'b0;
    check("s2_empty_ov",  f_ov,  0);
    check("s2_empty_cnt", f_cnt, 0);
    check("s2_sticky",    f_ovf, 1);

    // Flush with a concurrent write and pop.
    f_iv = 1'b1;
    f_din = 8'h21; step();
    f_din = 8'h22; step();
    f_din = 8'h23; step();
    check("s5_cnt3", f_cnt, 3);
    f_flush = 1'b1; f_din = 8'h99; f_or = 1'b1;
    step();
    {f_flush, f_iv, f_or} = '0;
    check("s5_cnt",  f_cnt,  0);
    check("s5_ov",   f_ov,   0);
    check("s5_ovf",  f_ovf,  0);
    check("s5_dout", f_dout, 8'hEE);
    check("s5_ir",   f_ir,   1);
    step();
    check("s5_nowr_cnt", f_cnt, 0);
    check("s5_nowr_ov",  f_ov,  0);

    // Registered output: two-cycle latency, fill to DEPTH+1.
    r_iv = 1'b1;
    r_din = 8'hA0; step();
    check("s3_lat_ov",  r_ov,  0);
    check("s3_lat_cnt", r_cnt, 1);
    r_din = 8'hA1; step();
    check("s3_ov",   r_ov,   1);
    check("s3_dout", r_dout, 8'hA0);
    check("s3_cnt2", r_cnt,  2);
    r_din = 8'hA2; step();
    r_din = 8'hA3; step();
    check("s3_ir4", r_ir, 1);
    r_din = 8'hA4; step();
    r_iv = 1'b0;
    check("s3_cnt5", r_cnt, 5);
    check("s3_ir5",  r_ir,  0);
    check("s3_af",   r_af,  1);
    check("s3_ovf",  r_ovf, 0);
    r_or = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("s3_b2b_ov",   r_ov,   1);
      check("s3_b2b_dout", r_dout, 8'hA0 + i);
      step();
    end
    r_or = 1'b0;
    check("s3_end_ov",   r_ov,   0);
    check("s3_end_dout", r_dout, 8'h5A);
    check("s3_end_cnt",  r_cnt,  0);

    // Steady write+pop at count=2 across several pointer wraps.
    r_iv = 1'b1;
    r_din = 8'hB0; step();
    r_din = 8'hB1; step();
    check("s4_cnt_start", r_cnt, 2);
    r_or = 1'b1;
    for (int k = 0; k < 20; k++) begin
      r_din = 8'hC0 + k;
      check("s4_cnt", r_cnt, 2);
      check("s4_dout", r_dout, (k == 0) ? 8'hB0 : (k == 1) ? 8'hB1 : 8'hC0 + k - 2);
      step();
    end
    {r_iv, r_or} = '0;
    check("s4_end_cnt",  r_cnt,  2);
    check("s4_end_dout", r_dout, 8'hC0 + 18);

    // Mid-cycle asynchronous reset with words held in both instances.
    f_iv = 1'b1;
    f_din = 8'h31; step();
    f_din = 8'h32; step();
    f_iv = 1'b0;
    check("s6_pre_cnt", f_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_f_cnt",  f_cnt,  0);
    check("s6_f_ov",   f_ov,   0);
    check("s6_f_dout", f_dout, 8'hEE);
    check("s6_r_cnt",  r_cnt,  0);
    check("s6_r_ov",   r_ov,   0);
    check("s6_r_dout", r_dout, 8'h5A);
    rst_n = 1'b1;
    step();
    f_din = 8'h41; f_iv = 1'b1;
    r_din = 8'h42; r_iv = 1'b1;
    step();
    {f_iv, r_iv} = '0;
    check("s6_f_wr_ov",   f_ov,   1);
    check("s6_f_wr_dout", f_dout, 8'h41);
    check("s6_f_wr_cnt",  f_cnt,  1);
    check("s6_r_wr_ov",   r_ov,   0);
    step();
    check("s6_r_wr2_ov",   r_ov,   1);
    check("s6_r_wr2_dout", r_dout, 8'h42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
